inst_fetch_axi: RTL

Instruction-fetch responder between the PC register and the AXI read port. Accepts one fetch address per request, issues a single-beat AXI4 read, and returns the instruction word to decode. Drives the PC stage's advance enable via `req_ready` and honours the pipeline flush that redirects the PC, discarding stale responses.

---
 rtl/inst_fetch_axi.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_axi.sv
// inst_fetch_axi: instruction-fetch responder between the PC register and an
// AXI4 read port. One fetch address is accepted per request, a single-beat
// AXI read is issued, and the instruction word is handed to decode. A flush
// (PC redirect) kills the outstanding fetch and discards its response.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_addr   fetch request from the PC stage
//   req_ready            combinational accept, drives the PC advance enable
//   flush                pipeline redirect, same signal as the PC clear
//   resp_*               instruction response to decode (valid/ready)
//   ar* / r*             AXI4 read address / read data channels
module inst_fetch_axi #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  AXI_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              arvalid_n, rready_n, resp_valid_n, resp_err_n;
  logic [ADDR_W-1:0] araddr_n, resp_addr_n;
  logic [DATA_W-1:0] resp_data_n;
  logic              drop, drop_n;
  logic              misaligned;
  logic              r_done;

  // Only one transaction is ever outstanding, so the read ID carries no information.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Fixed single-beat, word-sized, incrementing read.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign r_done     = rvalid & rlast;

  // New fetch is taken only when idle, or when the held response leaves this cycle.
  assign req_ready = req_valid & ~flush &
                     ((state == ST_IDLE) | ((state == ST_HOLD) & resp_ready));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      resp_addr  <= '0;
      resp_data  <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= state_n;
      arvalid    <= arvalid_n;
      rready     <= rready_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      araddr     <= araddr_n;
      resp_addr  <= resp_addr_n;
      resp_data  <= resp_data_n;
      drop       <= drop_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    arvalid_n    = arvalid;
    rready_n     = rready;
    resp_valid_n = resp_valid;
    resp_err_n   = resp_err;
    araddr_n     = araddr;
    resp_addr_n  = resp_addr;
    resp_data_n  = resp_data;
    drop_n       = drop;

    case (state)
      ST_IDLE: begin
      end

      ST_AR: begin
        // arvalid is never retracted; a flush only marks the result for discard.
        if (flush) drop_n = 1'b1;
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_R;
        end
      end

      ST_R: begin
        if (flush) drop_n = 1'b1;
        if (r_done) begin
          rready_n = 1'b0;
          // A flush landing on the completing beat also discards it.
          if (drop | flush) begin
            drop_n  = 1'b0;
            state_n = ST_IDLE;
          end else begin
            resp_valid_n = 1'b1;
            resp_data_n  = rdata;
            resp_addr_n  = araddr;
            resp_err_n   = (rresp != 2'b00);
            state_n      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (flush | resp_ready) begin
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
          state_n      = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Accept overrides the HOLD/IDLE exit above.
    if (req_ready) begin
      if (misaligned) begin
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b1;
        resp_data_n  = '0;
        resp_addr_n  = req_addr;
        state_n      = ST_HOLD;
      end else begin
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        araddr_n     = req_addr;
        arvalid_n    = 1'b1;
        state_n      = ST_AR;
      end
    end
  end

endmodule
